// File: rtl/n64adv2_cdc_pkg.sv
// Shared definitions for the clock-domain-crossing helpers: the launch FSM
// state encoding and the settle counter width.
package n64adv2_cdc_pkg;

  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

endpackage

// File: rtl/bit_sync_srst.sv
// Single-bit synchronizer chain with synchronous active-low reset and a clock
// enable, for asynchronous level/toggle signals entering a single-clock block.
module bit_sync_srst #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic clk_en,
  input  logic d_i,
  output logic q_o
);

  logic [stages-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync_q <= '0;
    end else if (clk_en) begin
      sync_q <= {sync_q[stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[stages-1];

endmodule

// File: rtl/register_launch.sv
// Launches a multi-bit register into a foreign clock domain with a toggle
// request/acknowledge handshake; reg_o only moves while nothing is in flight.
module register_launch
  import n64adv2_cdc_pkg::*;
#(
  parameter int                   reg_width       = 16,
  parameter logic [reg_width-1:0] reg_preset      = '0,
  parameter int                   settle_cycles   = 2,
  parameter int                   ack_sync_stages = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 clk_en,
  input  logic [reg_width-1:0] reg_i,
  input  logic                 ack_i,
  output logic [reg_width-1:0] reg_o,
  output logic                 req_o,
  output logic                 busy_o,
  output logic                 dropped_o
);

  localparam logic [SETTLE_CNT_W-1:0] SettleLoad = SETTLE_CNT_W'(settle_cycles - 1);

  state_e                  state_q, state_d;
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic [reg_width-1:0]    reg_q, reg_d;
  logic [reg_width-1:0]    reg_prev_q;
  logic                    req_q, req_d;
  logic                    ack_sync;

  bit_sync_srst #(
    .stages(ack_sync_stages)
  ) u_ack_sync (
    .clk   (clk),
    .nrst  (nrst),
    .clk_en(clk_en),
    .d_i   (ack_i),
    .q_o   (ack_sync)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      reg_q      <= reg_preset;
      reg_prev_q <= reg_preset;
      req_q      <= 1'b0;
    end else if (clk_en) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reg_q      <= reg_d;
      reg_prev_q <= reg_i;
      req_q      <= req_d;
    end
  end

  // Capture only from IDLE, so a transfer in flight always sees a frozen reg_o.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (reg_i != reg_q) begin
          reg_d   = reg_i;
          cnt_d   = SettleLoad;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          req_d   = ~req_q;
          state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_sync == req_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign reg_o     = reg_q;
  assign req_o     = req_q;
  assign busy_o    = (state_q == ST_SETTLE) || (state_q == ST_WAIT_ACK);
  assign dropped_o = clk_en && busy_o && (reg_i != reg_prev_q);

endmodule

// File: tb/tb_register_launch.sv
// Directed self-checking bench for register_launch with default parameters;
// the destination side is emulated by driving ack_i by hand.
module tb_register_launch;

  logic        clk = 1'b0;
  logic        nrst;
  logic        clk_en;
  logic [15:0] reg_i;
  logic        ack_i;
  logic [15:0] reg_o;
  logic        req_o;
  logic        busy_o;
  logic        dropped_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  register_launch dut (
    .clk      (clk),
    .nrst     (nrst),
    .clk_en   (clk_en),
    .reg_i    (reg_i),
    .ack_i    (ack_i),
    .reg_o    (reg_o),
    .req_o    (req_o),
    .busy_o   (busy_o),
    .dropped_o(dropped_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic en, input logic rstN, input logic ack);
    reg_i  = r;
    clk_en = en;
    nrst   = rstN;
    ack_i  = ack;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic sawActivity;
    logic stallBad;

    applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_reg", reg_o, 16'h0000);
    checkOutput("rst_req", req_o, 1'b0);
    checkOutput("rst_busy", busy_o, 1'b0);
    checkOutput("rst_drop", dropped_o, 1'b0);

    applyStimulus(16'h0000, 1'b1, 1'b1, 1'b0);
    sawActivity = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (req_o !== 1'b0 || busy_o !== 1'b0) sawActivity = 1'b1;
    end
    checkOutput("idle_quiet", sawActivity, 1'b0);

    // single launch with a 3-cycle loopback
    applyStimulus(16'hA5C3, 1'b1, 1'b1, 1'b0);
    checkOutput("idle_nodrop", dropped_o, 1'b0);
    tick(1);
    checkOutput("l1_reg", reg_o, 16'hA5C3);
    checkOutput("l1_busy", busy_o, 1'b1);
    checkOutput("l1_req_early", req_o, 1'b0);
    tick(1);
    checkOutput("l1_req_t2", req_o, 1'b0);
    tick(1);
    checkOutput("l1_req_t3", req_o, 1'b1);
    tick(3);
    applyStimulus(16'hA5C3, 1'b1, 1'b1, 1'b1);
    tick(2);
    checkOutput("l1_busy_sync", busy_o, 1'b1);
    tick(1);
    checkOutput("l1_idle", busy_o, 1'b0);

    // superseded values while busy
    applyStimulus(16'h0001, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("sup_reg1", reg_o, 16'h0001);
    tick(2);
    checkOutput("sup_req", req_o, 1'b0);
    applyStimulus(16'h0002, 1'b1, 1'b1, 1'b1);
    checkOutput("sup_drop2", dropped_o, 1'b1);
    tick(1);
    checkOutput("sup_drop_clr", dropped_o, 1'b0);
    checkOutput("sup_hold", reg_o, 16'h0001);
    applyStimulus(16'h0003, 1'b1, 1'b1, 1'b1);
    checkOutput("sup_drop3", dropped_o, 1'b1);
    tick(1);
    applyStimulus(16'h0003, 1'b1, 1'b1, 1'b0);
    tick(2);
    checkOutput("sup_busy_sync", busy_o, 1'b1);
    tick(1);
    checkOutput("sup_idle", busy_o, 1'b0);
    checkOutput("sup_not2", reg_o, 16'h0001);
    tick(1);
    checkOutput("sup_reg3", reg_o, 16'h0003);
    checkOutput("sup_busy3", busy_o, 1'b1);
    tick(2);
    checkOutput("sup_req3", req_o, 1'b1);
    applyStimulus(16'h0003, 1'b1, 1'b1, 1'b1);
    tick(3);
    checkOutput("sup_idle3", busy_o, 1'b0);

    // stalled acknowledge
    applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b1);
    tick(3);
    checkOutput("stall_req", req_o, 1'b0);
    stallBad = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (busy_o !== 1'b1 || reg_o !== 16'hBEEF) stallBad = 1'b1;
    end
    checkOutput("stall_stable", stallBad, 1'b0);
    applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b0);
    tick(2);
    checkOutput("stall_busy", busy_o, 1'b1);
    tick(1);
    checkOutput("stall_idle", busy_o, 1'b0);

    // clock-enable gating in SETTLE
    applyStimulus(16'h5555, 1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("cen_reg", reg_o, 16'h5555);
    applyStimulus(16'h6666, 1'b0, 1'b1, 1'b0);
    checkOutput("cen_drop_off", dropped_o, 1'b0);
    tick(5);
    checkOutput("cen_req_held", req_o, 1'b0);
    checkOutput("cen_reg_held", reg_o, 16'h5555);
    checkOutput("cen_drop_off2", dropped_o, 1'b0);
    applyStimulus(16'h5555, 1'b1, 1'b1, 1'b0);
    checkOutput("cen_drop_on", dropped_o, 1'b0);
    tick(1);
    checkOutput("cen_req_t2", req_o, 1'b0);
    tick(1);
    checkOutput("cen_req_t3", req_o, 1'b1);
    applyStimulus(16'h5555, 1'b1, 1'b1, 1'b1);
    tick(3);
    checkOutput("cen_idle", busy_o, 1'b0);

    // reset in the middle of a transfer
    applyStimulus(16'h0F0F, 1'b1, 1'b1, 1'b1);
    tick(3);
    applyStimulus(16'h0F0F, 1'b1, 1'b1, 1'b0);
    tick(3);
    checkOutput("pre_idle", busy_o, 1'b0);
    applyStimulus(16'h1234, 1'b1, 1'b1, 1'b0);
    tick(3);
    checkOutput("mid_req", req_o, 1'b1);
    checkOutput("mid_reg", reg_o, 16'h1234);
    applyStimulus(16'h1234, 1'b1, 1'b0, 1'b0);
    tick(1);
    checkOutput("mrst_reg", reg_o, 16'h0000);
    checkOutput("mrst_req", req_o, 1'b0);
    checkOutput("mrst_busy", busy_o, 1'b0);
    applyStimulus(16'h1234, 1'b1, 1'b1, 1'b0);
    tick(1);
    checkOutput("relaunch_reg", reg_o, 16'h1234);
    checkOutput("relaunch_busy", busy_o, 1'b1);
    tick(2);
    checkOutput("relaunch_req", req_o, 1'b1);
    applyStimulus(16'h1234, 1'b1, 1'b1, 1'b1);
    tick(3);
    checkOutput("relaunch_idle", busy_o, 1'b0);
    tick(1);
    checkOutput("relaunch_stay", busy_o, 1'b0);

    // value reverts while busy: no second launch
    applyStimulus(16'h7777, 1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(16'h8888, 1'b1, 1'b1, 1'b1);
    tick(1);
    applyStimulus(16'h7777, 1'b1, 1'b1, 1'b1);
    tick(1);
    checkOutput("rev_req", req_o, 1'b0);
    applyStimulus(16'h7777, 1'b1, 1'b1, 1'b0);
    tick(3);
    checkOutput("rev_idle", busy_o, 1'b0);
    tick(1);
    checkOutput("rev_stay", busy_o, 1'b0);
    checkOutput("rev_reg", reg_o, 16'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/register_launch.md
# register_launch

Source-side companion to the destination register synchronizer. It launches a multi-bit configuration register from the local clock domain to a foreign domain using a four-phase-free toggle handshake. The block captures `reg_i` whenever it differs from the last launched value, holds the captured value stable on `reg_o` and toggles `req_o` after a settle delay. It then waits for the destination's echoed toggle on `ack_i`. `reg_o` only changes while no transfer is in flight, so the destination can sample it safely once it sees the request toggle.

## Interface
- `reg_width`, 16, width of launched register
- `reg_preset`, `{reg_width{1'b0}}`, reset value of `reg_o` and of the last-launched copy
- `settle_cycles`, 2, cycles `reg_o` is held stable before `req_o` toggles (range 1..15)
- `ack_sync_stages`, 2, synchronizer depth on `ack_i` (2 or 3)
- `clk` in 1 — single clock
- `nrst` in 1 — reset; synchronous, active-low
- `clk_en` in 1 — state advances only when 1
- `reg_i` in reg_width — register value to publish
- `ack_i` in 1 — acknowledge toggle from the destination domain (asynchronous)
- `reg_o` out reg_width — launched value; stable between launches
- `req_o` out 1 — request toggle toward the destination
- `busy_o` out 1 — high in SETTLE and WAIT_ACK
- `dropped_o` out 1 — one-cycle pulse when `reg_i` changed while busy (an intermediate value was superseded)

## Operation
- Reset (`nrst`=0 at a clk edge, regardless of `clk_en`):
  - `reg_o`=`reg_preset`, `req_o`=0, ack synchronizer chain=0
  - state IDLE, settle counter=0, `busy_o`=0, `dropped_o`=0
- With `clk_en`=0, all registers hold and `dropped_o` is forced 0.
- IDLE:
  - If `reg_i` != `reg_o`: load `reg_o`<=`reg_i`, counter<=`settle_cycles`-1, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - Counter decrements each enabled cycle.
  - When the counter is 0: `req_o`<=~`req_o`, go to WAIT_ACK.
- WAIT_ACK: when the synchronized ack equals `req_o`, go to IDLE. There is no timeout; the block waits indefinitely.
- `reg_i` changes during SETTLE or WAIT_ACK:
  - They are not captured.
  - `dropped_o` pulses on the enabled cycle where `reg_i` differs from its previous-cycle sample while busy.
  - On return to IDLE the current `reg_i` is compared, so the latest value always wins.
- If `reg_i` returns to `reg_o` before the transfer ends, no further launch occurs.
- Comparison is a full-width equality; there is no per-bit masking.

## Timing
- `reg_i` differs from `reg_o` at enabled edge t (IDLE): `reg_o` is updated at t+1.
- `req_o` toggles at t+1+`settle_cycles` (defaults: t+3).
- `ack_i` toggle seen at edge a: the synchronized ack matches at a+`ack_sync_stages`, and the state is IDLE at the following edge.
- Back-to-back launch:
  - The next `reg_o` update occurs one edge after returning to IDLE.
  - Minimum launch period = 1 + `settle_cycles` + `ack_sync_stages` + 1 + destination round trip.
- `busy_o` is combinational from state: high from t+1 until the edge entering IDLE.
- Reset mid-transfer:
  - The transfer is abandoned and `req_o`=0.
  - The destination must be reset in the same event; system integration guarantees this.

## Structure
- Shared package `n64adv2_cdc_pkg`:
  - state encoding localparams `ST_IDLE`=2'd0, `ST_SETTLE`=2'd1, `ST_WAIT_ACK`=2'd2
  - counter width constant `SETTLE_CNT_W`=4
- Sub-module `bit_sync_srst`: a 1-bit synchronizer for `ack_i` with synchronous active-low reset, `clk_en` and a `stages` parameter. It is reusable by other single-clock, synchronous-reset blocks.

## Test plan
- Reset then idle: `nrst`=0 for 2 cycles, `reg_i`=`reg_preset` → `reg_o`=16'h0000, `req_o`=0, `busy_o`=0; no toggles over 50 cycles.
- Single launch: `reg_i`=16'hA5C3 at edge 10, with a loopback destination echoing `req_o` after 3 cycles → `reg_o`=16'hA5C3 at 11, `req_o`=1 at 13, IDLE at 13+3+2+1=19.
- Superseded values:
  - Sequence: `reg_i`=16'h0001 launched, then 16'h0002 at edge 15, then 16'h0003 at edge 16 while in WAIT_ACK.
  - Expected: `dropped_o` pulses at 15 and 16; the next launch carries 16'h0003; 16'h0002 never appears on `reg_o`.
- Stalled ack:
  - Stimulus: no echo for 1000 cycles.
  - Expected: `busy_o` stays 1 and `reg_o` is stable.
  - Then toggle `ack_i` → IDLE 3 edges later.
- `clk_en` gating: `clk_en`=0 during SETTLE for 5 cycles → `req_o` toggle delayed by exactly 5 cycles; `dropped_o`=0 throughout.
- Reset mid-transfer:
  - Stimulus: `nrst`=0 in WAIT_ACK with `reg_o`=16'h1234, `req_o`=1.
  - Expected: next edge gives `reg_o`=`reg_preset`, `req_o`=0, IDLE. After release with `reg_i`=16'h1234, a fresh launch occurs.
